// File: rtl/efpga_op_sequencer.sv
// Single-operation sequencer for the CPU eFPGA accelerator port: accepts a job,
// drives the fabric, waits delay and done (or timeout) and returns the results.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// S_IDLE       | ready for a job; eFPGA field outputs hold the last job
// S_LAUNCH     | one-cycle write strobe with enable; loads the delay counter
// S_WAIT_DELAY | enable held while the programmed delay counts down; done ignored
// S_WAIT_DONE  | enable held; wait for done, or timeout expiry if enabled
// S_RESP       | response valid until accepted; enable low
module efpga_op_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,

    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [31:0]      req_operand_a_i,
    input  logic [31:0]      req_operand_b_i,
    input  logic [1:0]       req_operator_i,
    input  logic [3:0]       req_delay_i,
    input  logic             abort_i,

    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [31:0]      rsp_result_a_o,
    output logic [31:0]      rsp_result_b_o,
    output logic [31:0]      rsp_result_c_o,
    output logic             rsp_timeout_o,

    output logic [31:0]      eFPGA_operand_a_o,
    output logic [31:0]      eFPGA_operand_b_o,
    output logic [1:0]       eFPGA_operator_o,
    output logic [3:0]       eFPGA_delay_o,
    output logic             eFPGA_en_o,
    output logic             eFPGA_write_strobe_o,
    input  logic             eFPGA_fpga_done_i,
    input  logic [31:0]      eFPGA_result_a_i,
    input  logic [31:0]      eFPGA_result_b_i,
    input  logic [31:0]      eFPGA_result_c_i,

    output logic             busy_o,
    output logic [CNT_W-1:0] job_count_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_DELAY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state;
    state_t          state_next;
    logic [3:0]      dly_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            to_expired;
    logic            accept;
    logic            capture;
    logic            expire;
    logic            rsp_fire;

    assign to_expired = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // abort outranks everything in the active states; done outranks timeout
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        capture    = 1'b0;
        expire     = 1'b0;
        rsp_fire   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid_i) begin
                    accept     = 1'b1;
                    state_next = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (abort_i) begin
                    state_next = S_IDLE;
                end else if (eFPGA_delay_o != 4'd0) begin
                    state_next = S_WAIT_DELAY;
                end else begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DELAY: begin
                if (abort_i) begin
                    state_next = S_IDLE;
                end else if (dly_cnt == 4'd1) begin
                    state_next = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (abort_i) begin
                    state_next = S_IDLE;
                end else if (eFPGA_fpga_done_i) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end else if (to_expired) begin
                    expire     = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rsp_fire   = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Decoded straight from the state register so reset clears them at once.
    assign req_ready_o          = (state == S_IDLE) && reset_ni;
    assign eFPGA_write_strobe_o = (state == S_LAUNCH);
    assign eFPGA_en_o           = (state == S_LAUNCH) || (state == S_WAIT_DELAY) ||
                                  (state == S_WAIT_DONE);
    assign rsp_valid_o          = (state == S_RESP);
    assign busy_o               = (state != S_IDLE);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            eFPGA_operand_a_o <= 32'd0;
            eFPGA_operand_b_o <= 32'd0;
            eFPGA_operator_o  <= 2'd0;
            eFPGA_delay_o     <= 4'd0;
        end else if (accept) begin
            eFPGA_operand_a_o <= req_operand_a_i;
            eFPGA_operand_b_o <= req_operand_b_i;
            eFPGA_operator_o  <= req_operator_i;
            eFPGA_delay_o     <= req_delay_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            dly_cnt <= 4'd0;
        end else if (state == S_LAUNCH) begin
            dly_cnt <= eFPGA_delay_o;
        end else if (state == S_WAIT_DELAY) begin
            dly_cnt <= dly_cnt - 4'd1;
        end
    end

    // Held at zero outside WAIT_DONE, so it always starts from zero on entry.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            to_cnt <= '0;
        end else if (state == S_WAIT_DONE) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rsp_result_a_o <= 32'd0;
            rsp_result_b_o <= 32'd0;
            rsp_result_c_o <= 32'd0;
            rsp_timeout_o  <= 1'b0;
        end else if (capture) begin
            rsp_result_a_o <= eFPGA_result_a_i;
            rsp_result_b_o <= eFPGA_result_b_i;
            rsp_result_c_o <= eFPGA_result_c_i;
            rsp_timeout_o  <= 1'b0;
        end else if (expire) begin
            rsp_result_a_o <= 32'd0;
            rsp_result_b_o <= 32'd0;
            rsp_result_c_o <= 32'd0;
            rsp_timeout_o  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            job_count_o <= '0;
        end else if (rsp_fire && !rsp_timeout_o) begin
            job_count_o <= job_count_o + CNT_W'(1);
        end
    end

endmodule
